// File: rtl/rsa_modexp_sched.sv
// Control scheduler for right-to-left binary square-and-multiply modular exponentiation.
// Walks the exponent LSB first, launching the multiplier and squarer and pairing their completions.
module rsa_modexp_sched #(
  parameter int EXP_W = 1024,
  parameter int CNT_W = 11
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ds_n,
  input  logic [EXP_W-1:0] inExp,
  input  logic             multrdy,
  input  logic             sqrrdy,
  output logic             multgo,
  output logic             sqrgo,
  output logic             bothrdy,
  output logic             ready,
  output logic [CNT_W-1:0] count
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t           state_q, state_d;
  logic [EXP_W-1:0] exp_q, exp_d;
  logic [EXP_W-1:0] exp_shift;
  logic [CNT_W-1:0] count_q, count_d;
  logic             mult_done_q, mult_done_d;
  logic             sqr_done_q, sqr_done_d;
  logic             arm_q, arm_d;
  logic             multgo_q, multgo_d;
  logic             sqrgo_q, sqrgo_d;
  logic             ready_q, ready_d;
  logic             accept;
  logic             mult_req, sqr_req;
  logic             mult_ok, sqr_ok;
  logic             both;

  // The current LSB selects the multiply; any remaining higher bit needs another squaring.
  assign exp_shift = exp_q >> 1;
  assign mult_req  = exp_q[0];
  assign sqr_req   = |exp_shift;
  assign accept    = ((state_q == S_IDLE) || (state_q == S_DONE)) && !ds_n && arm_q;

  always_comb begin
    state_d     = state_q;
    exp_d       = exp_q;
    count_d     = count_q;
    mult_done_d = mult_done_q;
    sqr_done_d  = sqr_done_q;
    ready_d     = ready_q;
    arm_d       = ds_n ? 1'b1 : arm_q;
    mult_ok     = !mult_req || mult_done_q || multrdy;
    sqr_ok      = !sqr_req || sqr_done_q || sqrrdy;
    both        = 1'b0;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (accept) begin
          exp_d       = inExp;
          count_d     = '0;
          mult_done_d = 1'b0;
          sqr_done_d  = 1'b0;
          arm_d       = 1'b0;
          if (inExp == '0) begin
            state_d = S_DONE;
            ready_d = 1'b1;
          end else begin
            state_d = S_ISSUE;
            ready_d = 1'b0;
          end
        end
      end
      S_ISSUE: begin
        state_d = S_WAIT;
      end
      S_WAIT: begin
        both = mult_ok && sqr_ok;
        if (both) begin
          exp_d       = exp_shift;
          count_d     = count_q + CNT_ONE;
          mult_done_d = 1'b0;
          sqr_done_d  = 1'b0;
          if (exp_shift == '0) begin
            state_d = S_DONE;
            ready_d = 1'b1;
          end else begin
            state_d = S_ISSUE;
          end
        end else begin
          // Completions of operations not launched this iteration are dropped here.
          mult_done_d = mult_done_q | (multrdy & mult_req);
          sqr_done_d  = sqr_done_q | (sqrrdy & sqr_req);
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    multgo_d = (state_d == S_ISSUE) && exp_d[0];
    sqrgo_d  = (state_d == S_ISSUE) && (|(exp_d >> 1));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      exp_q       <= '0;
      count_q     <= '0;
      mult_done_q <= 1'b0;
      sqr_done_q  <= 1'b0;
      arm_q       <= 1'b0;
      multgo_q    <= 1'b0;
      sqrgo_q     <= 1'b0;
      ready_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      exp_q       <= exp_d;
      count_q     <= count_d;
      mult_done_q <= mult_done_d;
      sqr_done_q  <= sqr_done_d;
      arm_q       <= arm_d;
      multgo_q    <= multgo_d;
      sqrgo_q     <= sqrgo_d;
      ready_q     <= ready_d;
    end
  end

  assign multgo  = multgo_q;
  assign sqrgo   = sqrgo_q;
  assign bothrdy = both;
  assign ready   = ready_q;
  assign count   = count_q;

endmodule

// File: doc/rsa_modexp_sched.md
RSA_MODEXP_SCHED -- requirements
Module: rsa_modexp_sched

Interface
REQ-001 Parameter EXP_W, default 1024, exponent width in bits.
REQ-002 Parameter CNT_W, default 11, width of iteration counter (must satisfy 2^CNT_W > EXP_W).
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 ds_n  input  1  active-low start request.
REQ-006 inExp  input  EXP_W  exponent, sampled only on start acceptance.
REQ-007 multrdy  input  1  one-cycle completion pulse from modular multiplier.
REQ-008 sqrrdy  input  1  one-cycle completion pulse from modular squarer.
REQ-009 multgo  output  1  one-cycle multiplier launch pulse.
REQ-010 sqrgo  output  1  one-cycle squarer launch pulse.
REQ-011 bothrdy  output  1  high in the cycle all operations required for the current iteration are complete.
REQ-012 ready  output  1  exponentiation complete; result valid in datapath.
REQ-013 count  output  CNT_W  number of completed iterations of the current or last run.

Function
REQ-014 The FSM SHALL have the states IDLE, ISSUE, WAIT and DONE; the method is right-to-left binary square-and-multiply, one exponent bit per iteration, LSB first.
REQ-015 The block SHALL keep an internal arm flag, set while ds_n=1 and cleared on start acceptance.
REQ-016 Start SHALL be accepted on an edge where the state is IDLE or DONE, ds_n=0 and arm=1; exp_reg<=inExp, count<=0, ready<=0, mult_done/sqr_done<=0.
REQ-017 On acceptance the next state SHALL be DONE if inExp==0 (no go pulses), else ISSUE.
REQ-018 In ISSUE (exactly one cycle) the block SHALL assert multgo iff exp_reg[0]=1 and sqrgo iff (exp_reg>>1)!=0; the next state is WAIT.
REQ-019 Pulses on multrdy and sqrrdy SHALL be latched into mult_done/sqr_done only in WAIT; pulses in IDLE, ISSUE or DONE SHALL be ignored.
REQ-020 bothrdy SHALL be combinational in WAIT: each required operation either has its done flag set or has its rdy input high this cycle; elsewhere bothrdy=0.
REQ-021 Multiplier and squarer completions MAY arrive in either order or in the same cycle; completion of an operation not issued this iteration SHALL be ignored.
REQ-022 On an edge with bothrdy=1: exp_reg<=exp_reg>>1, count<=count+1, both done flags cleared; next state DONE if the shifted value is 0, else ISSUE.
REQ-023 DONE SHALL hold ready=1 until the next start acceptance; a new start from DONE SHALL follow REQ-016.
REQ-024 ds_n changes during ISSUE/WAIT SHALL not affect operation apart from updating arm.
REQ-025 Iteration latency SHALL be 1 ISSUE cycle + WAIT cycles up to and including the last required rdy; no idle cycle between iterations.
REQ-026 The total number of iterations SHALL equal the bit position of the MSB of inExp + 1.

Reset
REQ-027 reset=1 SHALL force the state to IDLE immediately, with multgo=0, sqrgo=0, bothrdy=0, ready=0, count=0, exp_reg=0, done flags=0, arm=0.
REQ-028 reset asserted mid-run SHALL abort the run; no go pulse SHALL be issued until a new start is accepted after reset release and ds_n has been seen high.

Verification
REQ-029 inExp=0, ds_n high then low: no multgo/sqrgo; ready=1 from the cycle after acceptance; count=0.
REQ-030 inExp=1, multrdy returned 3 cycles after multgo: exactly one multgo, zero sqrgo; ready=1 one cycle after the multrdy edge; count=1.
REQ-031 inExp=4'b1011: go pattern per iteration (mult,sqr) = (1,1),(1,1),(0,1),(1,0); totals multgo=3, sqrgo=3, count=4, then ready=1.
REQ-032 Skewed completion: sqrrdy 2 cycles after go, multrdy 7 cycles after go: bothrdy only in the multrdy cycle; next ISSUE on the following cycle.
REQ-033 reset pulsed during WAIT of iteration 2 with inExp=8'hFF: all outputs 0 within the same cycle; late rdy pulses after reset produce no go pulse and no count change.
REQ-034 ds_n held low across completion: ready stays 1 and no restart; restart only after ds_n goes 1 then 0.
